// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: parametrised N-input, W-bit selector with a registered output
// stage, a valid/ready handshake and a 2-entry skid so back-pressure never
// drops data.
// Optional feature macro: MUX_SEL_CHECK_EN adds the sel_err output, which flags
// words accepted with an out-of-range select and travels with those words.
module mux_nx1_pipe #(
   parameter int WIDTH    = 3,
   parameter int CHANNELS = 2,
   parameter int SEL_W    = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel
`ifdef MUX_SEL_CHECK_EN
   ,
   output logic                      sel_err
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL1 = 2'd1,
      ST_FULL2 = 2'd2
   } state_t;

   // Channel picker; a select that matches no channel yields zero.
   function automatic logic [WIDTH-1:0] f_select(
      input logic [CHANNELS*WIDTH-1:0] data,
      input logic [SEL_W-1:0]          s
   );
      logic [WIDTH-1:0] result;
      result = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (int'(s) == k) begin
            result = data[k*WIDTH +: WIDTH];
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

   state_t             r_state;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_data;
   logic [SEL_W-1:0]   r_out_sel;
   logic [WIDTH-1:0]   r_skid_data;
   logic [SEL_W-1:0]   r_skid_sel;
   logic               w_accept;
   logic               w_xfer;
   logic [WIDTH-1:0]   w_sel_data;
`ifdef MUX_SEL_CHECK_EN
   logic               r_out_err;
   logic               r_skid_err;
   logic               w_sel_oor;
`endif

   // Handshake qualifiers and the selected word for the current cycle.
   always_comb begin
      w_accept   = in_valid & r_in_ready;
      w_xfer     = r_out_valid & out_ready;
      w_sel_data = f_select(in_data, sel);
`ifdef MUX_SEL_CHECK_EN
      w_sel_oor  = (int'(sel) >= CHANNELS);
`endif
   end

   // Output/skid state machine; in_ready is registered so out_ready never reaches it combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_skid_data <= '0;
         r_skid_sel  <= '0;
`ifdef MUX_SEL_CHECK_EN
         r_out_err   <= 1'b0;
         r_skid_err  <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_out_data  <= w_sel_data;
                  r_out_sel   <= sel;
`ifdef MUX_SEL_CHECK_EN
                  r_out_err   <= w_sel_oor;
`endif
                  r_out_valid <= 1'b1;
                  r_state     <= ST_FULL1;
               end
            end
            ST_FULL1: begin
               if (w_accept && w_xfer) begin
                  // OUT drains and refills in the same edge.
                  r_out_data <= w_sel_data;
                  r_out_sel  <= sel;
`ifdef MUX_SEL_CHECK_EN
                  r_out_err  <= w_sel_oor;
`endif
               end else if (w_accept) begin
                  // OUT is stalled, so the new word parks in the skid.
                  r_skid_data <= w_sel_data;
                  r_skid_sel  <= sel;
`ifdef MUX_SEL_CHECK_EN
                  r_skid_err  <= w_sel_oor;
`endif
                  r_in_ready  <= 1'b0;
                  r_state     <= ST_FULL2;
               end else if (w_xfer) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_EMPTY;
               end
            end
            ST_FULL2: begin
               if (w_xfer) begin
                  r_out_data <= r_skid_data;
                  r_out_sel  <= r_skid_sel;
`ifdef MUX_SEL_CHECK_EN
                  r_out_err  <= r_skid_err;
`endif
                  r_in_ready <= 1'b1;
                  r_state    <= ST_FULL1;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
`ifdef MUX_SEL_CHECK_EN
   assign sel_err   = r_out_err;
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Scoreboard bench for mux_nx1_pipe (WIDTH=8, CHANNELS=3, SEL_W=2).
// Expected words are queued on accept; a monitor pops them on each out transfer.
module tb_mux_nx1_pipe;
   localparam int W  = 8;
   localparam int CH = 3;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [SW-1:0]   sel = '0;
   logic [CH*W-1:0] in_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [W-1:0]    out_data;
   logic [SW-1:0]   out_sel;
`ifdef MUX_SEL_CHECK_EN
   logic            sel_err;
`endif

   typedef struct packed {
      logic [W-1:0]  d;
      logic [SW-1:0] s;
      logic          e;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   mux_nx1_pipe #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sel(out_sel)
`ifdef MUX_SEL_CHECK_EN
      , .sel_err(sel_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Stimulus pattern: channel k of word i carries i*7 + k*40 + 3.
   function automatic logic [CH*W-1:0] mk_data(input int i);
      logic [CH*W-1:0] r;
      for (int k = 0; k < CH; k++) r[k*W +: W] = 8'(i*7 + k*40 + 3);
      return r;
   endfunction

   function automatic logic [W-1:0] exp_of(input int i, input int s);
      return (s < CH) ? 8'(i*7 + s*40 + 3) : 8'h00;
   endfunction

   // Present one word and hold it until accepted; queue its expected result.
   task automatic send(input logic [CH*W-1:0] d, input logic [SW-1:0] s, input logic [W-1:0] ed);
      bit acc;
      exp_t e;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      sel      = s;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         if (in_ready === 1'b1) acc = 1'b1;
      end
      if (!acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout actual=no_accept expected=accept");
         in_valid = 1'b0;
         return;
      end
      e.d = ed;
      e.s = s;
      e.e = (int'(s) >= CH);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Monitor: every out transfer must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_output actual=%0h expected=none", out_data);
            end else begin
               e = sb_q.pop_front();
               chk("out_data", 64'(out_data), 64'(e.d));
               chk("out_sel", 64'(out_sel), 64'(e.s));
`ifdef MUX_SEL_CHECK_EN
               chk("sel_err", 64'(sel_err), 64'(e.e));
`endif
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CH*W-1:0] d;
      // Power-on reset
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_sel", 64'(out_sel), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic selection, including out-of-range sel and the in-range word after it
      out_ready = 1'b1;
      d = {8'h33, 8'h5A, 8'hC3};
      send(d, 2'd1, 8'h5A);
      chk("latency_valid", 64'(out_valid), 64'd1);
      send(d, 2'd0, 8'hC3);
      send(d, 2'd2, 8'h33);
      send(d, 2'd3, 8'h00);
      send(d, 2'd1, 8'h5A);
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("idle_after_basic", 64'(out_valid), 64'd0);

      // Back-pressure: two words fill OUT and SKID, third waits upstream
      out_ready = 1'b0;
      d = {8'h33, 8'h22, 8'h11};
      send(d, 2'd0, 8'h11);
      send(d, 2'd1, 8'h22);
      chk("in_ready_drop", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      sel = 2'd2;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_in_ready_low", 64'(in_ready), 64'd0);
         chk("bp_hold_data", 64'(out_data), 64'h11);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(d, 2'd2, 8'h33);
      for (int c = 0; c < 10 && sb_q.size() != 0; c++) @(posedge clk);
      #1;
      chk("bp_drained", 64'(sb_q.size()), 64'd0);

      // Asynchronous reset with OUT and SKID both full
      out_ready = 1'b0;
      send(mk_data(1), 2'd0, exp_of(1, 0));
      send(mk_data(2), 2'd1, exp_of(2, 1));
      chk("pre_rst_full", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_data", 64'(out_data), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_empty", 64'(out_valid), 64'd0);

      // Stall stability while in_data toggles
      send(mk_data(5), 2'd2, exp_of(5, 2));
      for (int c = 0; c < 10; c++) begin
         in_data = ~in_data;
         @(negedge clk);
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_data", 64'(out_data), 64'(exp_of(5, 2)));
         chk("stall_sel", 64'(out_sel), 64'd2);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Full throughput: one accept and one output every cycle
      for (int i = 0; i < 100; i++) begin
         exp_t e;
         in_valid = 1'b1;
         in_data  = mk_data(i);
         sel      = 2'((i*5 + i/3) % 4);
         @(negedge clk);
         chk("tp_in_ready", 64'(in_ready), 64'd1);
         if (i > 0) chk("tp_out_valid", 64'(out_valid), 64'd1);
         e.d = exp_of(i, int'(sel));
         e.s = sel;
         e.e = (int'(sel) >= CH);
         sb_q.push_back(e);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      for (int c = 0; c < 20 && (sb_q.size() != 0 || out_valid); c++) @(posedge clk);
      #1;
      chk("final_drained", 64'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
